// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM pipeline stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
   logic        mem_enable;
   logic        mem_rw;
   logic [1:0]  mem_size;
   logic        mem_se;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_busy;
   logic        misalign_err;

   modport master (
      output mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready, mem_busy, misalign_err
   );

   modport slave (
      input  mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
      output mem_rdata, mem_ready, mem_busy, misalign_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: big-endian byte-addressed RAM with byte/half/word access,
// programmable wait states, load extension, stall and completion/error strobes.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 1
) (
   input  logic clk,
   input  logic reset,
   data_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_ERR} state_t;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t                state_reg, state_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic                  rw_reg, se_reg;
   logic [1:0]            size_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [31:0]           wdata_reg;
   logic [31:0]           rdata_reg;

   logic [7:0]            ram [DEPTH];

   logic                  accept, misaligned, do_access;
   logic                  acc_rw, acc_se;
   logic [1:0]            acc_size;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [31:0]           acc_wdata;
   logic [ADDR_WIDTH-1:0] byte_addr [4];
   logic [31:0]           rd_word, load_value, wr_lane;
   logic [3:0]            wr_en;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^bus.mem_addr[31:ADDR_WIDTH];

   assign accept     = (state_reg == ST_IDLE) && bus.mem_enable;
   assign misaligned = ((bus.mem_size == 2'b01) && bus.mem_addr[0]) ||
                       (bus.mem_size[1] && (bus.mem_addr[1:0] != 2'b00));

   // With zero wait states the access happens on the accept edge itself, so use the live request.
   always_comb begin
      acc_rw    = rw_reg;
      acc_se    = se_reg;
      acc_size  = size_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      if (state_reg == ST_IDLE) begin
         acc_rw    = bus.mem_rw;
         acc_se    = bus.mem_se;
         acc_size  = bus.mem_size;
         acc_addr  = bus.mem_addr[ADDR_WIDTH-1:0];
         acc_wdata = bus.mem_wdata;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.mem_enable) begin
               if (misaligned) begin
                  state_next = ST_ERR;
               end else if (WAIT_STATES == 0) begin
                  state_next = ST_RESP;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = 4'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_reg == 4'd0) state_next = ST_RESP;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.mem_ready    = 1'b0;
      bus.misalign_err = 1'b0;
      bus.mem_busy     = 1'b0;
      case (state_reg)
         ST_IDLE: bus.mem_busy = bus.mem_enable;
         ST_WAIT: bus.mem_busy = 1'b1;
         ST_RESP: bus.mem_ready = 1'b1;
         ST_ERR: begin
            bus.mem_ready    = 1'b1;
            bus.misalign_err = 1'b1;
         end
         default: ;
      endcase
   end
   assign bus.mem_rdata = rdata_reg;

   // Gating with reset keeps an edge during reset from touching the RAM.
   assign do_access = reset && (state_next == ST_RESP);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_addr[gi]          = acc_addr + ADDR_WIDTH'(gi);
         assign rd_word[31-8*gi -: 8]  = ram[byte_addr[gi]];
      end
   endgenerate

   // Store data is left-justified so lane 0 always lands at the lowest address.
   always_comb begin
      wr_en   = 4'b1111;
      wr_lane = acc_wdata;
      case (acc_size)
         2'b00: begin
            wr_en   = 4'b1000;
            wr_lane = {acc_wdata[7:0], 24'd0};
         end
         2'b01: begin
            wr_en   = 4'b1100;
            wr_lane = {acc_wdata[15:0], 16'd0};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (acc_size)
         2'b00:   load_value = acc_se ? {{24{rd_word[31]}}, rd_word[31:24]} : {24'd0, rd_word[31:24]};
         2'b01:   load_value = acc_se ? {{16{rd_word[31]}}, rd_word[31:16]} : {16'd0, rd_word[31:16]};
         default: load_value = rd_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_access && acc_rw) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_en[3-i]) ram[byte_addr[i]] <= wr_lane[31-8*i -: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rw_reg    <= 1'b0;
         se_reg    <= 1'b0;
         size_reg  <= 2'b00;
         addr_reg  <= '0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
      end else begin
         if (accept) begin
            rw_reg    <= bus.mem_rw;
            se_reg    <= bus.mem_se;
            size_reg  <= bus.mem_size;
            addr_reg  <= bus.mem_addr[ADDR_WIDTH-1:0];
            wdata_reg <= bus.mem_wdata;
         end
         if (do_access && !acc_rw) rdata_reg <= load_value;
      end
   end
endmodule
